// File: rtl/jt9346_ctrl_pkg.sv
// Shared definitions for the 93C46-style EEPROM command controller.
//   - Opcode constants (2-bit field sent after the start bit)
//   - Extended sub-op codes (top two address bits when op == OP_EXT)
//   - FSM state encoding
//   - Helpers deciding which command phases a given op needs
package jt9346_pkg;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_GAP   = 3'd4,
    ST_POLL  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Commands that carry a data word after the address: WRITE and WRAL.
  function automatic logic has_wdata(input logic [1:0] op, input logic [1:0] sub);
    return (op == OP_WRITE) || ((op == OP_EXT) && (sub == EXT_WRAL));
  endfunction

  // Commands that start a program cycle and must wait for ready.
  function automatic logic needs_poll(input logic [1:0] op, input logic [1:0] sub);
    return (op == OP_WRITE) || (op == OP_ERASE) ||
           ((op == OP_EXT) && ((sub == EXT_WRAL) || (sub == EXT_ERAL)));
  endfunction

endpackage

// File: rtl/jt9346_ctrl_if.sv
// Host-side command bus of the EEPROM controller.
//   cmd_req/cmd_op/cmd_addr/cmd_din : command issued by the host
//   busy/done/dout/err               : status and read data from the controller
// Modports: master = host side, slave = controller side.
interface jt9346_ctrl_if #(
  parameter int CW = 6,
  parameter int DW = 16
);
  logic          cmd_req;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_addr;
  logic [DW-1:0] cmd_din;
  logic          busy;
  logic          done;
  logic [DW-1:0] dout;
  logic          err;

  modport master (
    output cmd_req, cmd_op, cmd_addr, cmd_din,
    input  busy, done, dout, err
  );

  modport slave (
    input  cmd_req, cmd_op, cmd_addr, cmd_din,
    output busy, done, dout, err
  );
endinterface

// File: rtl/jt9346_ctrl_tick.sv
// Serial-clock half-period timer.
//   clk, rst : system clock, async active-high reset
//   en       : run the timer (held cleared while low)
//   restart  : restart from the start of a low half
//   half     : strobe on the last clk of every half-period
//   sample   : strobe on the last clk of a high half (sdo sample point)
module jt9346_ctrl_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic half,
  output logic sample
);
  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNTW-1:0] cnt_r;
  logic            phase_r;   // 0 = low half, 1 = high half
  logic            last_s;

  assign last_s = (cnt_r == CNTW'(DIV - 1));
  assign half   = en & last_s;
  assign sample = en & last_s & phase_r;

  // Half-period counter and phase tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CNTW{1'b0}};
      phase_r <= 1'b0;
    end else if (restart || !en) begin
      cnt_r   <= {CNTW{1'b0}};
      phase_r <= 1'b0;
    end else if (last_s) begin
      cnt_r   <= {CNTW{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNTW'(1);
    end
  end
endmodule

// File: rtl/jt9346_ctrl.sv
// Parallel-command master for a 93C46-style serial EEPROM.
//   clk, rst          : system clock, async active-high reset
//   host (slave)      : command request/op/addr/data in; busy/done/dout/err out
//   sclk, sdi, scs    : serial clock, data and chip select to the EEPROM
//   sdo               : serial data / ready (1 = ready) from the EEPROM
// A command is shifted out as start bit, opcode and address, followed by a
// data word (WRITE/WRAL) or DW read pulses (READ). Program commands then
// poll sdo for ready, bounded by TOUT clk cycles.
module jt9346_ctrl
  import jt9346_pkg::*;
#(
  parameter int AW   = 6,
  parameter int CW   = AW,
  parameter int DW   = 16,
  parameter int DIV  = 4,
  parameter int TOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  jt9346_ctrl_if.slave host,
  output logic         sclk,
  output logic         sdi,
  output logic         scs,
  input  logic         sdo
);
  localparam int NCMD = 3 + CW;
  localparam int SW   = (NCMD > DW) ? NCMD : DW;
  localparam int BCW  = $clog2(SW + 1);
  localparam int PCW  = $clog2(TOUT + 1);

  state_t         state_r;
  logic [1:0]     op_r;
  logic [1:0]     sub_r;
  logic [DW-1:0]  din_r;
  logic [DW-1:0]  dout_r;
  logic [SW-1:0]  sreg_r;    // outgoing bits (MSB next) or incoming read bits (LSB in)
  logic [BCW-1:0] bcnt_r;    // bits left in the current phase
  logic [PCW-1:0] pcnt_r;
  logic           busy_r;
  logic           done_r;
  logic           err_r;
  logic           accept_s;
  logic           tick_en_s;
  logic           half_s;
  logic           sample_s;

  assign accept_s  = (state_r == ST_IDLE) & host.cmd_req;
  assign tick_en_s = (state_r != ST_IDLE);

  assign host.busy = busy_r;
  assign host.done = done_r;
  assign host.dout = dout_r;
  assign host.err  = err_r;

  jt9346_ctrl_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (tick_en_s),
    .restart (accept_s),
    .half    (half_s),
    .sample  (sample_s)
  );

  // Command FSM, shift register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      sub_r   <= 2'b00;
      din_r   <= {DW{1'b0}};
      dout_r  <= {DW{1'b0}};
      sreg_r  <= {SW{1'b0}};
      bcnt_r  <= {BCW{1'b0}};
      pcnt_r  <= {PCW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      sclk    <= 1'b0;
      sdi     <= 1'b0;
      scs     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk <= 1'b0;
          sdi  <= 1'b0;
          scs  <= 1'b0;
          if (host.cmd_req) begin
            op_r   <= host.cmd_op;
            sub_r  <= host.cmd_addr[CW-1 -: 2];
            din_r  <= host.cmd_din;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            scs    <= 1'b1;
            sdi    <= 1'b1;   // start bit goes out first
            sreg_r <= SW'({host.cmd_op, host.cmd_addr}) << (SW - CW - 2);
            bcnt_r <= BCW'(NCMD);
            state_r <= ST_CMD;
          end
        end
        ST_CMD, ST_WDATA, ST_RDATA: begin
          // sclk mirrors the timer phase; sdi only moves on the falling edge.
          if (half_s) begin
            sclk <= ~sclk;
          end
          if (sample_s) begin
            if (bcnt_r != BCW'(1)) begin
              bcnt_r <= bcnt_r - BCW'(1);
              if (state_r == ST_RDATA) begin
                sreg_r <= {sreg_r[SW-2:0], sdo};
              end else begin
                sdi    <= sreg_r[SW-1];
                sreg_r <= {sreg_r[SW-2:0], 1'b0};
              end
            end else if ((state_r == ST_CMD) && has_wdata(op_r, sub_r)) begin
              state_r <= ST_WDATA;
              bcnt_r  <= BCW'(DW);
              sdi     <= din_r[DW-1];
              sreg_r  <= SW'({din_r[DW-2:0], 1'b0}) << (SW - DW);
            end else if ((state_r == ST_CMD) && (op_r == OP_READ)) begin
              // The dummy 0 seen during the last address bit is skipped.
              state_r <= ST_RDATA;
              bcnt_r  <= BCW'(DW);
              sdi     <= 1'b0;
            end else begin
              state_r <= ST_GAP;
              sdi     <= 1'b0;
              scs     <= 1'b0;
              if (state_r == ST_RDATA) begin
                sreg_r <= {sreg_r[SW-2:0], sdo};
              end
            end
          end
        end
        ST_GAP: begin
          sclk <= 1'b0;
          sdi  <= 1'b0;
          scs  <= 1'b0;
          // One full low+high period of the timer gives 2*DIV cycles.
          if (sample_s) begin
            if (op_r == OP_READ) begin
              dout_r <= sreg_r[DW-1:0];
            end
            if (needs_poll(op_r, sub_r)) begin
              state_r <= ST_POLL;
              scs     <= 1'b1;
              pcnt_r  <= {PCW{1'b0}};
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_POLL: begin
          sclk <= 1'b0;
          sdi  <= 1'b0;
          if (sdo) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            scs     <= 1'b0;
          end else if (pcnt_r == PCW'(TOUT - 1)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            scs     <= 1'b0;
          end else begin
            pcnt_r <= pcnt_r + PCW'(1);
          end
        end
        ST_DONE: begin
          scs     <= 1'b0;
          sclk    <= 1'b0;
          sdi     <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          scs     <= 1'b0;
          sclk    <= 1'b0;
          sdi     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jt9346_ctrl.sv
// Directed bench for jt9346_ctrl with a small behavioural 93C46 model
// (64 x 16 bit, EWEN/EWDS/ERAL/WRAL/WRITE/READ/ERASE, busy after program).
module tb_jt9346_ctrl;
  import jt9346_pkg::*;

  localparam int CW   = 6;
  localparam int DW   = 16;
  localparam int DIV  = 2;
  localparam int TOUT = 100;

  logic clk = 1'b0;
  logic rst;
  logic sclk, sdi, scs, sdo;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  jt9346_ctrl_if #(.CW(CW), .DW(DW)) host ();

  jt9346_ctrl #(.AW(6), .CW(CW), .DW(DW), .DIV(DIV), .TOUT(TOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .sclk (sclk),
    .sdi  (sdi),
    .scs  (scs),
    .sdo  (sdo)
  );

  // ---------------- EEPROM model ----------------
  logic [15:0] mem [64];
  logic        mdl_clr;
  logic        stuck0;
  logic        ewen;
  logic        reading;
  logic        rbit;
  logic [15:0] rsh;
  logic [24:0] rx;
  logic [24:0] nrx;
  logic        sclk_d;
  int          nbits;
  int          busy_cnt;

  assign nrx = {rx[23:0], sdi};
  assign sdo = stuck0 ? 1'b0 : (reading ? rbit : (busy_cnt == 0));

  // Model samples sdi on sclk rising edges seen at the falling clk edge.
  always @(negedge clk) begin
    sclk_d <= sclk;
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (mdl_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      ewen <= 1'b0; reading <= 1'b0; rbit <= 1'b0; rsh <= 16'h0000;
      rx <= 25'd0; nbits <= 0; busy_cnt <= 0;
    end else if (!scs) begin
      nbits <= 0; reading <= 1'b0; rx <= 25'd0;
    end else if (sclk && !sclk_d) begin
      rx    <= nrx;
      nbits <= nbits + 1;
      if (reading) begin
        rbit <= rsh[15];
        rsh  <= {rsh[14:0], 1'b0};
      end
      if (nbits == 8) begin
        case (nrx[7:6])
          2'b10: begin reading <= 1'b1; rsh <= mem[nrx[5:0]]; rbit <= 1'b0; end
          2'b11: if (ewen) begin mem[nrx[5:0]] <= 16'hFFFF; busy_cnt <= 20; end
          2'b00: begin
            case (nrx[5:4])
              2'b11: ewen <= 1'b1;
              2'b00: ewen <= 1'b0;
              2'b10: if (ewen) begin
                for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
                busy_cnt <= 20;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (nbits == 24 && ewen) begin
        if (nrx[23:22] == 2'b01) begin
          mem[nrx[21:16]] <= nrx[15:0];
          busy_cnt <= 20;
        end else if (nrx[23:22] == 2'b00 && nrx[21:20] == 2'b01) begin
          for (int i = 0; i < 64; i++) mem[i] <= nrx[15:0];
          busy_cnt <= 20;
        end
      end
    end
  end

  // Count done pulses independently of the command tasks.
  always @(negedge clk) begin
    if (host.done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and wait (bounded) for done. lat counts clk cycles
  // from the request cycle through the done cycle inclusive.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [5:0] addr,
                         input logic [15:0] din, input int glitch_at,
                         output int lat, output logic err_acc);
    int   k;
    logic seen;
    @(negedge clk);
    host.cmd_req = 1'b1; host.cmd_op = op; host.cmd_addr = addr; host.cmd_din = din;
    k = 0; seen = 1'b0; err_acc = 1'b0;
    while (!seen && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) err_acc = host.err;
      host.cmd_req = (glitch_at != 0) && (k == glitch_at);
      if (host.cmd_req) begin
        host.cmd_op = OP_WRITE; host.cmd_addr = 6'd7; host.cmd_din = 16'hDEAD;
      end
      if (host.done) seen = 1'b1;
    end
    host.cmd_req = 1'b0;
    lat = k + 1;
    check_val({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_val({name, "_busy_at_done"}, {31'd0, host.busy}, 32'd1);
    @(posedge clk); #1;
    check_val({name, "_busy_after"}, {31'd0, host.busy}, 32'd0);
    check_val({name, "_done_1cyc"}, {31'd0, host.done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ea;
    int   d0;
    rst = 1'b1; mdl_clr = 1'b1; stuck0 = 1'b0;
    host.cmd_req = 1'b0; host.cmd_op = 2'b00; host.cmd_addr = 6'd0; host.cmd_din = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, host.busy}, 32'd0);
    check_val("rst_done", {31'd0, host.done}, 32'd0);
    check_val("rst_dout", {16'd0, host.dout}, 32'd0);
    check_val("rst_err",  {31'd0, host.err},  32'd0);
    check_val("rst_sclk", {31'd0, sclk}, 32'd0);
    check_val("rst_sdi",  {31'd0, sdi},  32'd0);
    check_val("rst_scs",  {31'd0, scs},  32'd0);
    rst = 1'b0; mdl_clr = 1'b0;
    repeat (2) @(negedge clk);

    // EWEN, write, read back
    run_cmd("ewen1", OP_EXT, 6'b110000, 16'h0000, 0, lat, ea);
    check_val("ewen1_lat", lat, 32'd42);
    check_val("ewen1_err", {31'd0, host.err}, 32'd0);
    run_cmd("wr_a55a", OP_WRITE, 6'd5, 16'hA55A, 0, lat, ea);
    check_val("wr_a55a_err", {31'd0, host.err}, 32'd0);
    run_cmd("rd5_a", OP_READ, 6'd5, 16'h0000, 0, lat, ea);
    check_val("rd5_a_lat", lat, 32'd106);
    check_val("rd5_a_dout", {16'd0, host.dout}, 32'h0000A55A);

    // Write with programming disabled has no effect
    run_cmd("ewds", OP_EXT, 6'b000000, 16'h0000, 0, lat, ea);
    check_val("ewds_lat", lat, 32'd42);
    check_val("ewds_dout_hold", {16'd0, host.dout}, 32'h0000A55A);
    run_cmd("wr_1234", OP_WRITE, 6'd5, 16'h1234, 0, lat, ea);
    run_cmd("rd5_b", OP_READ, 6'd5, 16'h0000, 0, lat, ea);
    check_val("rd5_b_dout", {16'd0, host.dout}, 32'h0000A55A);

    // Erase all
    run_cmd("ewen2", OP_EXT, 6'b110000, 16'h0000, 0, lat, ea);
    run_cmd("eral", OP_EXT, 6'b100000, 16'h0000, 0, lat, ea);
    check_val("eral_err", {31'd0, host.err}, 32'd0);
    run_cmd("rd0", OP_READ, 6'd0, 16'h0000, 0, lat, ea);
    check_val("rd0_dout", {16'd0, host.dout}, 32'h0000FFFF);
    run_cmd("rd63", OP_READ, 6'd63, 16'h0000, 0, lat, ea);
    check_val("rd63_dout", {16'd0, host.dout}, 32'h0000FFFF);

    // Ready never arrives: POLL times out after TOUT cycles
    stuck0 = 1'b1;
    run_cmd("wr_tout", OP_WRITE, 6'd9, 16'h1111, 0, lat, ea);
    check_val("wr_tout_lat", lat, 32'd206);
    check_val("wr_tout_err", {31'd0, host.err}, 32'd1);
    check_val("wr_tout_dout_hold", {16'd0, host.dout}, 32'h0000FFFF);
    stuck0 = 1'b0;
    run_cmd("ewen3", OP_EXT, 6'b110000, 16'h0000, 0, lat, ea);
    check_val("err_clr_on_accept", {31'd0, ea}, 32'd0);
    check_val("ewen3_err", {31'd0, host.err}, 32'd0);

    // Request while busy is ignored
    d0 = done_cnt;
    run_cmd("rd_glitch", OP_READ, 6'd63, 16'h0000, 3, lat, ea);
    repeat (120) @(negedge clk);
    check_val("glitch_one_done", done_cnt - d0, 32'd1);
    check_val("glitch_lat", lat, 32'd106);
    check_val("glitch_dout", {16'd0, host.dout}, 32'h0000FFFF);

    // Reset in the middle of a write data phase
    run_cmd("wr_5aa5", OP_WRITE, 6'd5, 16'h5AA5, 0, lat, ea);
    d0 = done_cnt;
    @(negedge clk);
    host.cmd_req = 1'b1; host.cmd_op = OP_WRITE; host.cmd_addr = 6'd5; host.cmd_din = 16'h0BAD;
    @(posedge clk); #1;
    host.cmd_req = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check_val("abort_scs_pre", {31'd0, scs}, 32'd1);
    check_val("abort_busy_pre", {31'd0, host.busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("abort_scs", {31'd0, scs}, 32'd0);
    check_val("abort_sclk", {31'd0, sclk}, 32'd0);
    check_val("abort_sdi", {31'd0, sdi}, 32'd0);
    check_val("abort_busy", {31'd0, host.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("abort_no_done", done_cnt - d0, 32'd0);
    run_cmd("rd5_c", OP_READ, 6'd5, 16'h0000, 0, lat, ea);
    check_val("rd5_c_dout", {16'd0, host.dout}, 32'h00005AA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jt9346_ctrl.md
Name: jt9346_ctrl

Overview:
- Parallel-command master for the 93C46-style serial EEPROM model. Sits directly upstream of the EEPROM's chip interface and drives its sclk/sdi/scs; sdo comes back from it.
- A host issues one command (op, address, data) with a request pulse. The block serialises it, collects read data, and polls ready/busy after program cycles.
- Intended users: game-core glue logic and testbenches that need EEPROM access without bit-banging.

Parameters:
- AW, 6, memory address bits (informational; must match the EEPROM instance).
- CW, AW, command address-field bits sent after the 2-bit opcode.
- DW, 16, data word width (8 or 16).
- DIV, 4, clk cycles per sclk half-period (≥1).
- TOUT, 65535, maximum clk cycles spent polling ready before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- cmd_req  in  1  command request; sampled only in IDLE.
- cmd_op  in  2  opcode: 00 ext, 01 write, 10 read, 11 erase.
- cmd_addr  in  CW  address field; top 2 bits select the ext sub-op.
- cmd_din  in  DW  write data, MSB first.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- dout  out  DW  read data; valid from done and held until the next read completes.
- err  out  1  ready-poll timeout on the last command; cleared on the next accepted request.
- sclk  out  1  serial clock to the EEPROM.
- sdi  out  1  serial data to the EEPROM.
- scs  out  1  chip select to the EEPROM, active high.
- sdo  in  1  serial data / ready (1 = ready) from the EEPROM.

Behaviour:
- Reset values: busy=0, done=0, dout=0, err=0, sclk=0, sdi=0, scs=0; FSM goes to IDLE. Reset mid-command aborts immediately with no done pulse.
- Tick generator: counts DIV clk cycles and produces a strobe per half-period. It is active only outside IDLE and restarts at 0 on request acceptance.
- Acceptance:
  - cmd_req=1 in IDLE latches op/addr/din and clears err.
  - busy rises the next cycle and stays high until the cycle after the done pulse.
  - cmd_req while busy is ignored (not queued).
- Serial timing:
  - sdi changes only while sclk=0; the EEPROM samples on the sclk rising edge.
  - Every bit is DIV cycles low followed by DIV cycles high.
  - The controller samples sdo on the last clk of each high half.
- States:
  - IDLE: scs=0, sclk=0.
  - CMD: scs=1. Shifts 3+CW bits MSB-first: start bit 1, op[1:0], addr[CW-1:0].
  - WDATA: entered for write, or for ext with addr top bits 01 (WRAL). Shifts DW bits of din, MSB first.
  - RDATA: entered for read. Issues DW further pulses and shifts the sampled sdo into dout, MSB first. The dummy 0 emitted after the last address bit is not captured.
  - GAP: scs=0, sclk=0 for 2*DIV cycles.
  - POLL: used for write, erase, WRAL (ext 01) and ERAL (ext 10). scs=1, sclk=0; samples sdo every clk. sdo=1 moves to DONE. After TOUT cycles without sdo=1, err=1 and the FSM moves to DONE.
  - DONE: scs=0; done=1 for one cycle; then IDLE.
- State sequences:
  - read: CMD → RDATA → GAP → DONE.
  - EWEN/EWDS (ext 11/00): CMD → GAP → DONE.
  - write/WRAL: CMD → WDATA → GAP → POLL → DONE.
  - erase/ERAL: CMD → GAP → POLL → DONE.
- Bit counter is sized clog2(max(3+CW, DW)+1); it reloads on each state entry. The poll counter saturates at TOUT.
- Command latency (no poll) = 1 + 2*DIV*(3+CW [+DW]) + 2*DIV + 1 clk cycles.
- With DIV=1, sclk toggles every clk; sampling rules are unchanged.

Decomposition:
- Package jt9346_pkg: opcode constants OP_EXT/OP_WRITE/OP_READ/OP_ERASE; ext sub-codes EXT_EWDS=00, EXT_WRAL=01, EXT_ERAL=10, EXT_EWEN=11; the FSM state enum.
- Sub-module jt9346_ctrl_tick: DIV half-period counter with enable and restart inputs; outputs a half-period strobe and an end-of-high-half sample strobe.
- The FSM and shift register live in jt9346_ctrl.

Test Plan (paired with jt9346, DW=16, CW=6, DIV=2):
- EWEN (op 00, addr 110000), then write addr 5 = 0xA55A, then read addr 5 → done after each command, err=0, dout=0xA55A, busy low between commands.
- EWDS, write addr 5 = 0x1234, read addr 5 → dout stays 0xA55A.
- EWEN, ERAL, read addr 0 and addr 63 → dout=0xFFFF both times.
- Replace the EEPROM with an sdo held at 0, issue a write, TOUT=100 → POLL lasts 100 cycles, then err=1 and done=1; the next request clears err.
- Pulse cmd_req 3 cycles into a read → second request ignored; exactly one done pulse.
- Assert rst mid-WDATA → scs/sclk/sdi/busy go 0 immediately with no done pulse; a following read returns the pre-reset contents.
